burst_mem_responder: RTL and testbench



---
 rtl/burst_mem_responder.sv | 155 +++++++++++++++
 tb/tb_burst_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : burst_mem_responder
// Purpose  : Memory end of the 64-bit bmem burst link. It serves 32-byte line
//            reads and 4-beat line writes from an internal line store.
// Revision : 1.0  initial release
// ============================================================================
module burst_mem_responder #(
   parameter int MEM_LINES    = 16,
   parameter int READ_LATENCY = 4,
   parameter int QUEUE_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bmem_addr,
   input  logic        bmem_read,
   input  logic        bmem_write,
   input  logic [63:0] bmem_wdata,
   output logic        bmem_ready,
   output logic [31:0] bmem_raddr,
   output logic [63:0] bmem_rdata,
   output logic        bmem_rvalid,
   output logic        protocol_err
);

   localparam int c_IDX_W = $clog2(MEM_LINES);
   localparam int c_PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int c_LAT_W = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_W1 = 2'd1, S_W2 = 2'd2, S_W3 = 2'd3} wstate_t;

   logic [255:0]         r_mem    [MEM_LINES];
   logic [255:0]         r_q_line [QUEUE_DEPTH];
   logic [31:0]          r_q_base [QUEUE_DEPTH];
   logic [c_LAT_W-1:0]   r_q_wait [QUEUE_DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic [1:0]           r_beat;
   wstate_t              r_wstate;
   logic [191:0]         r_wbuf;
   logic [c_IDX_W-1:0]   r_widx;
   logic                 r_err;

   logic                 w_wr_active;
   logic                 w_full;
   logic                 w_rd_accept;
   logic                 w_pop;
   logic                 w_err;
   logic [c_IDX_W-1:0]   w_idx;
   logic [255:0]         w_head_line;
   logic                 w_unused_addr;

   function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_wr_active   = (r_wstate != S_IDLE);
   assign w_full        = (r_count == c_CNT_W'(QUEUE_DEPTH));
   assign bmem_ready    = !w_full || w_wr_active;
   assign w_rd_accept   = bmem_read && bmem_ready && !bmem_write && !w_wr_active;
   assign w_idx         = bmem_addr[5 +: c_IDX_W];
   assign w_unused_addr = ^bmem_addr[4:0];

   // The head entry drives the read channel once its latency has elapsed.
   assign w_head_line   = r_q_line[r_rd_ptr];
   assign bmem_rvalid   = (r_count != '0) && (r_q_wait[r_rd_ptr] == '0);
   assign w_pop         = bmem_rvalid && (r_beat == 2'd3);
   assign bmem_rdata    = bmem_rvalid ? w_head_line[{r_beat, 6'b0} +: 64] : 64'd0;
   assign bmem_raddr    = bmem_rvalid ? r_q_base[r_rd_ptr] : 32'd0;
   assign protocol_err  = r_err;

   always_comb begin
      w_err = 1'b0;
      if (!w_wr_active) begin
         w_err = bmem_read && bmem_write && bmem_ready;
      end else begin
         w_err = bmem_read || !bmem_write;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate <= S_IDLE;
         r_wbuf   <= '0;
         r_widx   <= '0;
         r_err    <= 1'b0;
         for (int i = 0; i < MEM_LINES; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_err <= w_err;
         case (r_wstate)
            S_IDLE: begin
               if (bmem_write && bmem_ready && !bmem_read) begin
                  r_wbuf[63:0] <= bmem_wdata;
                  r_widx       <= w_idx;
                  r_wstate     <= S_W1;
               end
            end
            S_W1: begin
               r_wbuf[127:64] <= bmem_wdata;
               r_wstate       <= bmem_write ? S_W2 : S_IDLE;
            end
            S_W2: begin
               r_wbuf[191:128] <= bmem_wdata;
               r_wstate        <= bmem_write ? S_W3 : S_IDLE;
            end
            S_W3: begin
               // A dropped final beat leaves the store untouched.
               if (bmem_write) begin
                  r_mem[r_widx] <= {bmem_wdata, r_wbuf};
               end
               r_wstate <= S_IDLE;
            end
            default: r_wstate <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_beat   <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            r_q_wait[i] <= '0;
         end
      end else begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (r_q_wait[i] != '0) begin
               r_q_wait[i] <= r_q_wait[i] - 1'b1;
            end
         end
         // Per-entry countdown cannot alias no matter how long an entry waits.
         if (w_rd_accept) begin
            r_q_line[r_wr_ptr] <= r_mem[w_idx];
            r_q_base[r_wr_ptr] <= {bmem_addr[31:5], 5'b0};
            r_q_wait[r_wr_ptr] <= c_LAT_W'(READ_LATENCY - 1);
            r_wr_ptr           <= f_next(r_wr_ptr);
         end
         if (bmem_rvalid) begin
            r_beat <= r_beat + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         r_count <= r_count + c_CNT_W'(w_rd_accept) - c_CNT_W'(w_pop);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_mem_responder
// Purpose  : Self-checking bench for burst_mem_responder with a cycle-schedule
//            reference model, a directed read table and randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_burst_mem_responder;

   localparam int LAT = 4;
   localparam int QD  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_write;
   logic [63:0] bmem_wdata;
   logic        bmem_ready;
   logic [31:0] bmem_raddr;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;
   logic        protocol_err;

   burst_mem_responder #(.MEM_LINES(16), .READ_LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
      .clk(clk), .rst(rst), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
      .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
      .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: line store, scheduled read responses, write burst position.
   typedef struct { int first; logic [31:0] base; logic [255:0] line; } rd_t;
   rd_t          pend[$];
   logic [255:0] mm [16];
   int           last_end;
   int           wpos;
   logic [255:0] wbuf;
   logic [3:0]   widx;
   logic         err_m;

   typedef struct { logic [31:0] addr; logic [31:0] base; logic [255:0] line; } vec_t;
   vec_t tbl [5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      pend.delete();
      for (int i = 0; i < 16; i++) mm[i] = '0;
      last_end = -100;
      wpos     = 0;
      wbuf     = '0;
      widx     = '0;
      err_m    = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance model.
   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [63:0] d);
      logic         rdy_m;
      logic         hit;
      logic [255:0] ln;
      int           beat;
      rd_t          e;
      bmem_read  = r;
      bmem_write = w;
      bmem_addr  = a;
      bmem_wdata = d;
      while (pend.size() > 0 && pend[0].first + 3 < cyc) void'(pend.pop_front());
      rdy_m = (pend.size() < QD) || (wpos != 0);
      hit   = (pend.size() > 0) && (pend[0].first <= cyc);
      chk("ready", {63'd0, bmem_ready}, {63'd0, rdy_m});
      chk("rvalid", {63'd0, bmem_rvalid}, {63'd0, hit});
      if (hit) begin
         beat = cyc - pend[0].first;
         ln   = pend[0].line;
         chk("rdata", bmem_rdata, ln[64*beat +: 64]);
         chk("raddr", {32'd0, bmem_raddr}, {32'd0, pend[0].base});
      end
      chk("protocol_err", {63'd0, protocol_err}, {63'd0, err_m});
      err_m = 1'b0;
      if (wpos == 0) begin
         if (rdy_m) begin
            if (r && w) err_m = 1'b1;
            else if (w) begin
               wbuf[63:0] = d;
               widx       = a[8:5];
               wpos       = 1;
            end else if (r) begin
               e.first  = (cyc + LAT > last_end + 1) ? cyc + LAT : last_end + 1;
               last_end = e.first + 3;
               e.base   = {a[31:5], 5'b0};
               e.line   = mm[a[8:5]];
               pend.push_back(e);
            end
         end
      end else begin
         if (r) err_m = 1'b1;
         if (!w) begin
            err_m = 1'b1;
            wpos  = 0;
         end else begin
            wbuf[64*wpos +: 64] = d;
            if (wpos == 3) begin
               mm[widx] = wbuf;
               wpos     = 0;
            end else wpos++;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      @(negedge clk);
      rst = 1'b0;
      cyc++;
      model_clear();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 64'd0);
   endtask

   task automatic drain();
      int guard = 0;
      while ((pend.size() > 0 || wpos != 0) && guard < 100) begin
         step(1'b0, 1'b0, 32'd0, 64'd0);
         guard++;
      end
   endtask

   task automatic write_burst(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3);
      step(1'b0, 1'b1, a, d0);
      step(1'b0, 1'b1, a, d1);
      step(1'b0, 1'b1, a, d2);
      step(1'b0, 1'b1, a, d3);
   endtask

   // Issue a read on an idle channel and compare latency, base and all four beats.
   task automatic read_expect(input string nm, input logic [31:0] a, input logic [31:0] base,
                              input logic [255:0] line);
      int waited = 0;
      drain();
      step(1'b1, 1'b0, a, 64'd0);
      while (!bmem_rvalid && waited < 40) begin
         step(1'b0, 1'b0, 32'd0, 64'd0);
         waited++;
      end
      if (!bmem_rvalid) chk({nm, "_timeout"}, {63'd0, bmem_rvalid}, 64'd1);
      else begin
         chk({nm, "_latency"}, 64'(waited), 64'(LAT - 1));
         for (int k = 0; k < 4; k++) begin
            chk({nm, "_data"}, bmem_rdata, line[64*k +: 64]);
            chk({nm, "_base"}, {32'd0, bmem_raddr}, {32'd0, base});
            step(1'b0, 1'b0, 32'd0, 64'd0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [255:0] l40;
      logic [255:0] l80;
      logic [255:0] laa;
      int           nbeat;
      int           guard;
      l40 = {B4, B3, B2, B1};
      l80 = {64'h8D, 64'h8C, 64'h8B, 64'h8A};
      laa = {BA, BA, BA, BA};
      tbl[0] = '{32'h0000_0040, 32'h0000_0040, l40};
      tbl[1] = '{32'h0000_005C, 32'h0000_0040, l40};
      tbl[2] = '{32'h0000_0060, 32'h0000_0060, 256'd0};
      tbl[3] = '{32'h0000_0440, 32'h0000_0440, l40};
      tbl[4] = '{32'hFFFF_FE5F, 32'hFFFF_FE40, l40};

      rst = 1'b1; bmem_read = 1'b0; bmem_write = 1'b0; bmem_addr = '0; bmem_wdata = '0;
      repeat (3) @(negedge clk);
      do_reset();
      chk("reset_ready", {63'd0, bmem_ready}, 64'd1);
      chk("reset_rvalid", {63'd0, bmem_rvalid}, 64'd0);
      chk("reset_rdata", bmem_rdata, 64'd0);
      chk("reset_raddr", {32'd0, bmem_raddr}, 64'd0);
      chk("reset_err", {63'd0, protocol_err}, 64'd0);

      write_burst(32'h40, B1, B2, B3, B4);
      idle(1);
      for (int i = 0; i < 5; i++) read_expect("table", tbl[i].addr, tbl[i].base, tbl[i].line);

      // Five back-to-back reads against a four-entry queue.
      drain();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 32), 64'd0);
      chk("full_ready", {63'd0, bmem_ready}, 64'd0);
      nbeat = 0;
      guard = 0;
      while (!bmem_ready && guard < 40) begin
         if (bmem_rvalid) nbeat++;
         step(1'b1, 1'b0, 32'h80, 64'd0);
         guard++;
      end
      chk("ready_returns", {63'd0, bmem_ready}, 64'd1);
      if (bmem_rvalid) nbeat++;
      step(1'b1, 1'b0, 32'h80, 64'd0);
      for (int i = 0; i < 30; i++) begin
         if (bmem_rvalid) nbeat++;
         step(1'b0, 1'b0, 32'd0, 64'd0);
      end
      chk("beat_count", 64'(nbeat), 64'd20);

      // Queued read keeps its snapshot while the line is rewritten.
      drain();
      step(1'b1, 1'b0, 32'h40, 64'd0);
      write_burst(32'h40, BA, BA, BA, BA);
      chk("queued_old_beat1", bmem_rdata, B2);
      read_expect("after_commit", 32'h40, 32'h40, laa);

      // Aborted burst and read/write collision.
      write_burst(32'h80, 64'h8A, 64'h8B, 64'h8C, 64'h8D);
      step(1'b0, 1'b1, 32'h80, 64'hDEAD);
      step(1'b0, 1'b1, 32'h80, 64'hBEEF);
      step(1'b0, 1'b0, 32'h80, 64'd0);
      chk("abort_err", {63'd0, protocol_err}, 64'd1);
      read_expect("abort_keep", 32'h80, 32'h80, l80);
      step(1'b1, 1'b1, 32'h80, 64'hFFFF);
      chk("collide_err", {63'd0, protocol_err}, 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk("collide_no_beat", {63'd0, bmem_rvalid}, 64'd0);
         step(1'b0, 1'b0, 32'd0, 64'd0);
      end
      read_expect("collide_keep", 32'h80, 32'h80, l80);

      // Reset during beat 1 of a response, then during W2.
      drain();
      step(1'b1, 1'b0, 32'h40, 64'd0);
      idle(LAT);
      chk("pre_reset_beat1", bmem_rdata, BA);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         chk("post_reset_rvalid", {63'd0, bmem_rvalid}, 64'd0);
         step(1'b0, 1'b0, 32'd0, 64'd0);
      end
      write_burst(32'h20, B1, B2, B3, B4);
      step(1'b0, 1'b1, 32'h20, B1);
      step(1'b0, 1'b1, 32'h20, B2);
      do_reset();
      chk("post_reset2_ready", {63'd0, bmem_ready}, 64'd1);
      for (int i = 0; i < 16; i++) read_expect("zero_store", 32'(i * 32), 32'(i * 32), 256'd0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         int          op;
         logic [31:0] a;
         a  = $urandom;
         op = $urandom_range(0, 9);
         if (op <= 3) step(1'b1, 1'b0, a, 64'd0);
         else if (op <= 5) idle($urandom_range(1, 3));
         else if (op <= 8) begin
            int cut;
            int inj;
            cut = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
            inj = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 9;
            for (int k = 0; k < 4; k++) begin
               step(k == inj, k < cut, a, {$urandom, $urandom});
            end
         end else step(1'b1, 1'b1, a, {$urandom, $urandom});
      end
      drain();
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
